// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and its memory.
interface fetch_unit_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory request, one-entry skid buffer for stalls,
// and a drain state that discards the reply to a request made stale by a redirect.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                clk,
    input  logic                resetl,
    input  logic                stall_n,
    input  logic                redirect,
    input  logic [63:0]         redirect_pc,
    fetch_unit_if.master        imem,
    output logic [31:0]         if_instr,
    output logic [63:0]         if_nextseqpc,
    output logic                if_valid
);

    typedef enum logic [1:0] {StReq, StHold, StDrain} state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] nseq_q, nseq_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [63:0] skid_nseq_q, skid_nseq_d;
    logic [63:0] addr_inc;
    logic        slot_free;
    logic        req;

    assign addr_inc  = addr_q + 64'd4;
    assign slot_free = !valid_q || stall_n;

    // State register
    always_ff @(posedge clk) begin
        if (!resetl) begin
            state_q <= StReq;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReq: begin
                if (redirect) begin
                    state_d = imem.imem_ack ? StReq : StDrain;
                end else if (imem.imem_ack && !slot_free) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (redirect || stall_n) begin
                    state_d = StReq;
                end
            end
            StDrain: begin
                if (!redirect && imem.imem_ack) begin
                    state_d = StReq;
                end
            end
            default: state_d = StReq;
        endcase
    end

    // Output logic
    always_comb begin
        req = (state_q != StHold);
    end

    // Datapath next values; a redirect flushes everything regardless of state.
    always_comb begin
        pc_d         = pc_q;
        addr_d       = addr_q;
        instr_d      = instr_q;
        nseq_d       = nseq_q;
        valid_d      = valid_q;
        skid_instr_d = skid_instr_q;
        skid_nseq_d  = skid_nseq_q;
        if (redirect) begin
            pc_d         = redirect_pc;
            valid_d      = 1'b0;
            instr_d      = 32'h0;
            nseq_d       = 64'h0;
            skid_instr_d = 32'h0;
            skid_nseq_d  = 64'h0;
            // Without an ack the stale request must stay on the bus until it completes.
            if ((state_q == StReq && imem.imem_ack) || state_q == StHold) begin
                addr_d = redirect_pc;
            end
        end else begin
            unique case (state_q)
                StReq: begin
                    if (imem.imem_ack) begin
                        pc_d = addr_inc;
                        if (slot_free) begin
                            instr_d = imem.imem_rdata;
                            nseq_d  = addr_inc;
                            valid_d = 1'b1;
                            addr_d  = addr_inc;
                        end else begin
                            skid_instr_d = imem.imem_rdata;
                            skid_nseq_d  = addr_inc;
                        end
                    end else if (slot_free) begin
                        valid_d = 1'b0;
                    end
                end
                StHold: begin
                    if (stall_n) begin
                        instr_d      = skid_instr_q;
                        nseq_d       = skid_nseq_q;
                        valid_d      = 1'b1;
                        addr_d       = pc_q;
                        skid_instr_d = 32'h0;
                        skid_nseq_d  = 64'h0;
                    end
                end
                StDrain: begin
                    if (imem.imem_ack) begin
                        addr_d = pc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetl) begin
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            instr_q      <= 32'h0;
            nseq_q       <= 64'h0;
            valid_q      <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_nseq_q  <= 64'h0;
        end else begin
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            instr_q      <= instr_d;
            nseq_q       <= nseq_d;
            valid_q      <= valid_d;
            skid_instr_q <= skid_instr_d;
            skid_nseq_q  <= skid_nseq_d;
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = addr_q;
    assign if_instr       = instr_q;
    assign if_nextseqpc   = nseq_q;
    assign if_valid       = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run checked against a
// program-order model of the instruction stream delivered to IF/ID.
module tb_fetch_unit;

    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        resetl;
    logic        stall_n;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [31:0] if_instr;
    logic [63:0] if_nextseqpc;
    logic        if_valid;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .resetl       (resetl),
        .stall_n      (stall_n),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem         (bus),
        .if_instr     (if_instr),
        .if_nextseqpc (if_nextseqpc),
        .if_valid     (if_valid)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          mem_mode = 0;    // 0 zero-wait, 1 two-cycle latency, 2 random, 3 never ack
    int          ack_pct = 100;
    int          mem_wait = 0;
    int          consumed = 0;
    logic [63:0] exp_pc;          // address of the next instruction IF/ID must receive

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: memory answers, model consumes, edge, then post-edge rule checks.
    task automatic step();
        logic        ack;
        logic        req_b;
        logic [63:0] addr_b;
        logic        rst_b;
        logic        redir_b;
        req_b   = bus.imem_req;
        addr_b  = bus.imem_addr;
        rst_b   = !resetl;
        redir_b = redirect;
        case (mem_mode)
            0:       ack = req_b;
            1:       ack = req_b && (mem_wait == 1);
            2:       ack = req_b && ($urandom_range(0, 99) < ack_pct);
            default: ack = 1'b0;
        endcase
        if (mem_mode == 1) mem_wait = (req_b && !ack) ? mem_wait + 1 : 0;
        bus.imem_ack   = ack;
        bus.imem_rdata = ack ? word_of(addr_b) : $urandom;

        if (rst_b) begin
            exp_pc = RESET_PC;
        end else if (redir_b) begin
            exp_pc = redirect_pc;
        end else if (stall_n && if_valid) begin
            check("stream_instr", {32'h0, if_instr}, {32'h0, word_of(exp_pc)});
            check("stream_nseq", if_nextseqpc, exp_pc + 64'd4);
            exp_pc = exp_pc + 64'd4;
            consumed++;
        end

        @(posedge clk);
        @(negedge clk);

        if (rst_b) begin
            check("rst_valid", {63'h0, if_valid}, 64'h0);
            check("rst_addr", bus.imem_addr, RESET_PC);
            check("rst_instr", {32'h0, if_instr}, 64'h0);
            check("rst_nseq", if_nextseqpc, 64'h0);
            check("rst_req", {63'h0, bus.imem_req}, 64'h1);
        end else begin
            if (req_b && !ack) check("addr_stable", bus.imem_addr, addr_b);
            if (redir_b) begin
                check("redir_valid", {63'h0, if_valid}, 64'h0);
                check("redir_instr", {32'h0, if_instr}, 64'h0);
                check("redir_nseq", if_nextseqpc, 64'h0);
            end
        end
    endtask

    task automatic reset_dut();
        resetl   = 1'b0;
        stall_n  = 1'b1;
        redirect = 1'b0;
        step();
        step();
        resetl = 1'b1;
    endtask

    initial begin
        resetl         = 1'b0;
        stall_n        = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = 64'h0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        exp_pc         = RESET_PC;
        @(negedge clk);

        // Zero-wait streaming from reset
        mem_mode = 0;
        reset_dut();
        check("z_addr0", bus.imem_addr, 64'h0);
        check("z_valid0", {63'h0, if_valid}, 64'h0);
        step();
        check("z_addr1", bus.imem_addr, 64'h4);
        check("z_nseq1", if_nextseqpc, 64'h4);
        check("z_valid1", {63'h0, if_valid}, 64'h1);
        check("z_instr1", {32'h0, if_instr}, {32'h0, word_of(64'h0)});
        step();
        check("z_addr2", bus.imem_addr, 64'h8);
        check("z_nseq2", if_nextseqpc, 64'h8);
        step();
        check("z_nseq3", if_nextseqpc, 64'hC);

        // Two-cycle memory latency
        reset_dut();
        mem_mode = 1;
        mem_wait = 0;
        step();
        check("l_addr1", bus.imem_addr, 64'h0);
        check("l_valid1", {63'h0, if_valid}, 64'h0);
        step();
        check("l_addr2", bus.imem_addr, 64'h4);
        check("l_valid2", {63'h0, if_valid}, 64'h1);
        step();
        check("l_valid3", {63'h0, if_valid}, 64'h0);
        step();
        check("l_valid4", {63'h0, if_valid}, 64'h1);
        check("l_nseq4", if_nextseqpc, 64'h8);

        // Three-cycle stall fills the skid buffer
        mem_mode = 0;
        reset_dut();
        step();
        step();
        stall_n = 1'b0;
        step();
        check("s_req1", {63'h0, bus.imem_req}, 64'h0);
        check("s_nseq1", if_nextseqpc, 64'h8);
        step();
        step();
        check("s_req3", {63'h0, bus.imem_req}, 64'h0);
        check("s_nseq3", if_nextseqpc, 64'h8);
        check("s_valid3", {63'h0, if_valid}, 64'h1);
        stall_n = 1'b1;
        step();
        check("s_nseq4", if_nextseqpc, 64'hC);
        check("s_addr4", bus.imem_addr, 64'hC);
        check("s_req4", {63'h0, bus.imem_req}, 64'h1);
        step();
        check("s_nseq5", if_nextseqpc, 64'h10);

        // Redirect while a request is outstanding drains the stale reply
        reset_dut();
        repeat (4) step();
        check("d_addr_pre", bus.imem_addr, 64'h10);
        mem_mode = 3;
        step();
        redirect    = 1'b1;
        redirect_pc = 64'h400;
        step();
        redirect = 1'b0;
        check("d_addr1", bus.imem_addr, 64'h10);
        check("d_req1", {63'h0, bus.imem_req}, 64'h1);
        step();
        check("d_addr2", bus.imem_addr, 64'h10);
        mem_mode = 0;
        step();
        check("d_addr3", bus.imem_addr, 64'h400);
        check("d_valid3", {63'h0, if_valid}, 64'h0);
        step();
        check("d_nseq4", if_nextseqpc, 64'h404);
        check("d_valid4", {63'h0, if_valid}, 64'h1);
        check("d_instr4", {32'h0, if_instr}, {32'h0, word_of(64'h400)});

        // Redirect while stalled with the skid buffer full
        reset_dut();
        step();
        step();
        stall_n = 1'b0;
        step();
        check("k_req", {63'h0, bus.imem_req}, 64'h0);
        redirect    = 1'b1;
        redirect_pc = 64'h2000;
        step();
        redirect = 1'b0;
        check("k_addr", bus.imem_addr, 64'h2000);
        check("k_req2", {63'h0, bus.imem_req}, 64'h1);
        stall_n = 1'b1;
        step();
        check("k_nseq1", if_nextseqpc, 64'h2004);
        step();
        check("k_nseq2", if_nextseqpc, 64'h2008);

        // Address wrap at the top of the 64-bit space
        reset_dut();
        redirect    = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect = 1'b0;
        check("w_addr0", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        check("w_nseq", if_nextseqpc, 64'h0);
        check("w_addr", bus.imem_addr, 64'h0);
        check("w_instr", {32'h0, if_instr}, {32'h0, word_of(64'hFFFF_FFFF_FFFF_FFFC)});
        step();
        check("w_nseq2", if_nextseqpc, 64'h4);

        // Reset abandons an outstanding request
        mem_mode = 3;
        step();
        resetl = 1'b0;
        step();
        resetl   = 1'b1;
        mem_mode = 0;
        step();
        check("r_nseq", if_nextseqpc, RESET_PC + 64'd4);
        check("r_instr", {32'h0, if_instr}, {32'h0, word_of(RESET_PC)});

        // Randomized traffic
        mem_mode = 2;
        consumed = 0;
        for (int b = 0; b < 6; b++) begin
            ack_pct = $urandom_range(20, 100);
            for (int i = 0; i < 500; i++) begin
                stall_n  = ($urandom_range(0, 99) < 70);
                redirect = ($urandom_range(0, 99) < 4);
                if ($urandom_range(0, 3) == 0) begin
                    redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | {60'h0, 2'($urandom), 2'b00};
                end else begin
                    redirect_pc = {$urandom, $urandom} & ~64'h3;
                end
                resetl = ($urandom_range(0, 199) != 0);
                step();
            end
        end
        resetl   = 1'b1;
        redirect = 1'b0;
        check("liveness", {63'h0, (consumed >= 100)}, 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
